// File: rtl/appmul_share_ctrl.sv
// Round-robin scheduler that time-shares one approximate 8x8 multiplier among NREQ requesters.
// Each accepted operand pair is registered into the multiplier. The tagged product is returned on a valid/ready port.
module appmul_share_ctrl #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [8*NREQ-1:0]   req_a,
  input  logic [8*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]     req_ready,
  output logic [7:0]          mul_a,
  output logic [7:0]          mul_b,
  input  logic [15:0]         mul_s,
  output logic                rsp_valid,
  output logic [ID_W-1:0]     rsp_id,
  output logic [15:0]         rsp_prod,
  input  logic                rsp_ready,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [ID_W:0] NREQ_W = (ID_W+1)'(NREQ);

  state_t          state;
  state_t          state_next;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] cur_id;
  logic [ID_W-1:0] pick_id;
  logic            pick_found;
  logic            accept;
  logic [7:0]      pick_a;
  logic [7:0]      pick_b;
  logic [ID_W-1:0] ptr_after_pick;

  // Search from rr_ptr upward with one spare bit so the modulo wrap never overflows.
  always_comb begin
    logic [ID_W:0] idx;
    pick_found = 1'b0;
    pick_id    = '0;
    idx        = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (idx >= NREQ_W) begin
        idx = idx - NREQ_W;
      end
      if (!pick_found && req_valid[idx[ID_W-1:0]]) begin
        pick_found = 1'b1;
        pick_id    = idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    pick_a = 8'h00;
    pick_b = 8'h00;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_id == ID_W'(i)) begin
        pick_a = req_a[8*i +: 8];
        pick_b = req_b[8*i +: 8];
      end
    end
  end

  always_comb begin
    logic [ID_W:0] nxt;
    nxt = {1'b0, pick_id} + (ID_W+1)'(1);
    if (nxt >= NREQ_W) begin
      nxt = '0;
    end
    ptr_after_pick = nxt[ID_W-1:0];
  end

  assign accept = (state == IDLE) && pick_found;
  assign busy   = (state != IDLE);

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = accept && (pick_id == ID_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = MUL;
      MUL:     state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operands stay put after a transaction so the shared multiplier does not toggle while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      cur_id    <= '0;
      mul_a     <= 8'h00;
      mul_b     <= 8'h00;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_prod  <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mul_a  <= pick_a;
            mul_b  <= pick_b;
            cur_id <= pick_id;
            rr_ptr <= ptr_after_pick;
          end
        end
        MUL: begin
          rsp_prod  <= mul_s;
          rsp_id    <= cur_id;
          rsp_valid <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
